mdma_desc_req_fifo_ctl: RTL and testbench

- Synchronous FIFO controller that drives one 48b x 512-entry descriptor-request RAM through the RAM interface master modport.
- Turns a push valid/ready stream into RAM writes, prefetches RAM reads into a 2-entry output skid buffer, and presents a pop valid/ready stream.
- Tracks total occupancy, flags almost-full, and reports RAM ECC errors (rdbe/rsbe).
- Sits between the descriptor-request producer and the write engine.

---
 rtl/mdma_desc_req_fifo_ctl_if.sv | 19 +
 rtl/mdma_desc_req_fifo_ctl.sv | 142 ++++++++++++++
 tb/tb_mdma_desc_req_fifo_ctl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdma_desc_req_fifo_ctl_if.sv
// RAM port bundle for the 48b x 512 descriptor-request RAM.
// m: controller side (drives writes and read requests).
// s: RAM side (returns read data one cycle after ren, with ECC status).
interface mdma_48bx512_48bwe_ram_if #(
  parameter int DW = 48,
  parameter int AW = 9
);
  logic [AW-1:0] wadr;
  logic          wen;
  logic [DW-1:0] wdat;
  logic          ren;
  logic [AW-1:0] radr;
  logic [DW-1:0] rdat;
  logic          rsbe;
  logic          rdbe;

  modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
  modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);
endinterface

// File: rtl/mdma_desc_req_fifo_ctl.sv
// Descriptor-request FIFO controller.
// Push stream -> RAM writes; RAM reads are prefetched into a 2-entry skid
// buffer whose head is the pop stream. Tracks occupancy (RAM + in-flight
// read + skid), almost-full, and RAM ECC errors.
// Optional: define MDMA_DESC_FIFO_SBE_CNT_EN to add the sbe_cnt output
// (saturating count of corrected single-bit errors).
module mdma_desc_req_fifo_ctl #(
  parameter int DEPTH        = 512,
  parameter int DW           = 48,
  parameter int AFULL_THRESH = 496
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  output logic                   push_rdy,
  input  logic [DW-1:0]          push_dat,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [DW-1:0]          pop_dat,
  output logic                   pop_dbe,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   afull,
  output logic                   empty,
  output logic                   dbe_err,
  input  logic                   clr_err,
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
  output logic [15:0]            sbe_cnt,
`endif
  mdma_48bx512_48bwe_ram_if.m    ram
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_OCC = (AW+1)'(AFULL_THRESH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic [AW:0]   occ_nxt;
  logic          inflight;

  logic [DW-1:0] skid_dat [2];
  logic          skid_dbe [2];
  logic          skid_hd;
  logic [1:0]    skid_cnt;
  logic          skid_tl;

  logic          push_acc;
  logic          pop_acc;
  logic          rd_issue;
  logic          ret_vld;
  logic [2:0]    pend;

  // Handshakes, prefetch decision and next occupancy.
  // The prefetch slot check credits a pop accepted this cycle so a read can be
  // issued every cycle while streaming; without it the skid would stall 1 in 3.
  always_comb begin
    push_rdy = !rst && (occ != FULL_OCC);
    push_acc = push_vld && push_rdy;
    pop_vld  = !rst && (skid_cnt != 2'd0);
    pop_acc  = pop_vld && pop_rdy;
    pend     = 3'(skid_cnt) + 3'(inflight) - 3'(pop_acc);
    rd_issue = !rst && (ram_cnt != '0) && (pend < 3'd2);
    ret_vld  = inflight && !rst;
    skid_tl  = skid_hd ^ skid_cnt[0];
    occ_nxt  = occ + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
  end

  assign ram.wen  = push_acc;
  assign ram.wadr = wptr;
  assign ram.wdat = push_dat;
  assign ram.ren  = rd_issue;
  assign ram.radr = rptr;

  assign pop_dat = skid_dat[skid_hd];
  assign pop_dbe = pop_vld && skid_dbe[skid_hd];

  // RAM pointers, read-in-flight flag and occupancy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      occ      <= '0;
      afull    <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_acc) wptr <= wptr + AW'(1);
      if (rd_issue) rptr <= rptr + AW'(1);
      ram_cnt  <= ram_cnt + (AW+1)'(push_acc) - (AW+1)'(rd_issue);
      inflight <= rd_issue;
      occ      <= occ_nxt;
      afull    <= (occ_nxt >= AFULL_OCC);
      empty    <= (occ_nxt == '0);
    end
  end

  // Skid buffer control: head index and entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_hd  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (pop_acc) skid_hd <= ~skid_hd;
      skid_cnt <= skid_cnt + 2'(ret_vld) - 2'(pop_acc);
    end
  end

  // Skid buffer storage: read return lands in the tail slot.
  always_ff @(posedge clk) begin
    if (ret_vld) begin
      skid_dat[skid_tl] <= ram.rdat;
      skid_dbe[skid_tl] <= ram.rdbe;
    end
  end

  // Sticky uncorrectable-error flag; a new error wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbe_err <= 1'b0;
    end else if (ret_vld && ram.rdbe) begin
      dbe_err <= 1'b1;
    end else if (clr_err) begin
      dbe_err <= 1'b0;
    end
  end

`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
  // Saturating corrected-error counter; clear with a coincident error gives 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbe_cnt <= '0;
    end else if (clr_err) begin
      sbe_cnt <= 16'(ret_vld && ram.rsbe);
    end else if (ret_vld && ram.rsbe && (sbe_cnt != '1)) begin
      sbe_cnt <= sbe_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mdma_desc_req_fifo_ctl.sv
// Testbench for mdma_desc_req_fifo_ctl with a behavioural 1-cycle-latency RAM
// that stores per-word ECC flags so errors follow the word they were tagged on.
module tb_mdma_desc_req_fifo_ctl;
  localparam int DW    = 48;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_vld;
  logic          push_rdy;
  logic [DW-1:0] push_dat;
  logic          pop_vld;
  logic          pop_rdy;
  logic [DW-1:0] pop_dat;
  logic          pop_dbe;
  logic [AW:0]   occ;
  logic          afull;
  logic          empty;
  logic          dbe_err;
  logic          clr_err;
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
  logic [15:0]   sbe_cnt;
`endif

  mdma_48bx512_48bwe_ram_if #(.DW(DW), .AW(AW)) ram_bus ();

  mdma_desc_req_fifo_ctl #(.DEPTH(DEPTH), .DW(DW), .AFULL_THRESH(496)) dut (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_rdy (push_rdy),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .pop_rdy  (pop_rdy),
    .pop_dat  (pop_dat),
    .pop_dbe  (pop_dbe),
    .occ      (occ),
    .afull    (afull),
    .empty    (empty),
    .dbe_err  (dbe_err),
    .clr_err  (clr_err),
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
    .sbe_cnt  (sbe_cnt),
`endif
    .ram      (ram_bus)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [DW-1:0] mem     [DEPTH];
  logic          mem_dbe [DEPTH];
  logic          mem_sbe [DEPTH];
  logic          inj_dbe;
  logic          inj_sbe;

  always @(posedge clk) begin
    if (ram_bus.wen) begin
      mem[ram_bus.wadr]     <= ram_bus.wdat;
      mem_dbe[ram_bus.wadr] <= inj_dbe;
      mem_sbe[ram_bus.wadr] <= inj_sbe;
    end
    if (ram_bus.ren) begin
      ram_bus.rdat <= mem[ram_bus.radr];
      ram_bus.rdbe <= mem_dbe[ram_bus.radr];
      ram_bus.rsbe <= mem_sbe[ram_bus.radr];
    end else begin
      ram_bus.rdbe <= 1'b0;
      ram_bus.rsbe <= 1'b0;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [DW-1:0] dat;
    logic          dbe;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [AW-1:0] exp_wptr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every accepted pop against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && pop_vld && pop_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h, required no word", pop_dat);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_dat", 64'(pop_dat), 64'(mon_e.dat));
        chk("pop_dbe", 64'(pop_dbe), 64'(mon_e.dbe));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    push_vld = 1'b0;
    inj_dbe  = 1'b0;
    inj_sbe  = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic dbe, input logic sbe);
    exp_t e;
    push_vld = 1'b1;
    push_dat = d;
    inj_dbe  = dbe;
    inj_sbe  = sbe;
    #1;
    chk("push_rdy", 64'(push_rdy), 64'd1);
    chk("wen", 64'(ram_bus.wen), 64'd1);
    chk("wadr", 64'(ram_bus.wadr), 64'(exp_wptr));
    chk("wdat", 64'(ram_bus.wdat), 64'(d));
    e.dat = d;
    e.dbe = dbe;
    exp_q.push_back(e);
    exp_wptr = exp_wptr + AW'(1);
  endtask

  task automatic wait_empty(input int budget);
    for (int k = 0; k < budget && empty !== 1'b1; k++) step();
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] base;
    logic [AW-1:0] ra;

    rst = 1'b1; push_vld = 1'b0; pop_rdy = 1'b0; clr_err = 1'b0;
    push_dat = '0; inj_dbe = 1'b0; inj_sbe = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_push_rdy", 64'(push_rdy), 64'd0);
    chk("rst_wen", 64'(ram_bus.wen), 64'd0);
    chk("rst_ren", 64'(ram_bus.ren), 64'd0);
    chk("rst_pop_vld", 64'(pop_vld), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_pop_dbe", 64'(pop_dbe), 64'd0);
    chk("rst_dbe_err", 64'(dbe_err), 64'd0);
    chk("post_rst_push_rdy", 64'(push_rdy), 64'd1);

    // Single word: push cycle 0, ren cycle 1, pop_vld cycle 3
    pop_rdy = 1'b1;
    push_word(48'hA5A5_0000_1234, 1'b0, 1'b0);
    step(); idle(); settle();
    chk("sw_ren", 64'(ram_bus.ren), 64'd1);
    chk("sw_radr", 64'(ram_bus.radr), 64'd0);
    chk("sw_occ1", 64'(occ), 64'd1);
    step(); settle();
    chk("sw_pop_vld_c2", 64'(pop_vld), 64'd0);
    step(); settle();
    chk("sw_pop_vld_c3", 64'(pop_vld), 64'd1);
    chk("sw_occ3", 64'(occ), 64'd1);
    step(); settle();
    chk("sw_occ_end", 64'(occ), 64'd0);
    chk("sw_empty", 64'(empty), 64'd1);

    // Fill to full with the consumer stalled
    pop_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_word({16'hF111, 32'(i)}, 1'b0, 1'b0);
      step();
      chk("fill_occ", 64'(occ), 64'(i + 1));
      if (i + 1 == 495) chk("afull_495", 64'(afull), 64'd0);
      if (i + 1 == 496) chk("afull_496", 64'(afull), 64'd1);
    end
    idle(); settle();
    chk("full_push_rdy", 64'(push_rdy), 64'd0);
    chk("full_occ", 64'(occ), 64'd512);
    chk("full_afull", 64'(afull), 64'd1);
    push_vld = 1'b1; push_dat = 48'hDEAD_DEAD_DEAD;
    settle();
    chk("full_wen_blocked", 64'(ram_bus.wen), 64'd0);
    step(); idle(); settle();
    chk("full_513_ignored", 64'(occ), 64'd512);

    // Full with simultaneous push and pop: pop wins, push rejected
    push_vld = 1'b1; push_dat = 48'hBAD0_BAD0_BAD0; pop_rdy = 1'b1;
    settle();
    chk("fpp_push_rdy", 64'(push_rdy), 64'd0);
    chk("fpp_wen", 64'(ram_bus.wen), 64'd0);
    chk("fpp_pop_vld", 64'(pop_vld), 64'd1);
    step(); idle(); pop_rdy = 1'b0; settle();
    chk("fpp_occ", 64'(occ), 64'd511);
    chk("fpp_push_rdy_next", 64'(push_rdy), 64'd1);
    pop_rdy = 1'b1;
    wait_empty(700);
    chk("drain_occ", 64'(occ), 64'd0);

    // Stream 1500 words at full rate with wrap
    base = exp_wptr;
    for (int i = 0; i < 1500; i++) begin
      push_word({16'h5700, 32'(i * 7 + 3)}, 1'b0, 1'b0);
      if (i >= 1) begin
        ra = AW'(32'(base) + 32'(i) - 1);
        chk("st_ren", 64'(ram_bus.ren), 64'd1);
        chk("st_radr", 64'(ram_bus.radr), 64'(ra));
      end
      if (i >= 3) begin
        chk("st_pop_vld", 64'(pop_vld), 64'd1);
        chk("st_occ", 64'(occ), 64'd3);
      end
      step();
    end
    idle();
    wait_empty(20);

    // ECC: double-bit error on word 5, single-bit on words 2, 3, 7
    settle();
    chk("ecc_dbe_err_pre", 64'(dbe_err), 64'd0);
    for (int i = 0; i < 8; i++) begin
      push_word({16'hECC0, 32'(i)}, 1'(i == 4), 1'(i == 1 || i == 2 || i == 6));
      step();
    end
    idle();
    wait_empty(20);
    step(); settle();
    chk("ecc_dbe_err_set", 64'(dbe_err), 64'd1);
    step(); step(); step(); settle();
    chk("ecc_dbe_err_sticky", 64'(dbe_err), 64'd1);
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
    chk("ecc_sbe_cnt", 64'(sbe_cnt), 64'd3);
`endif
    clr_err = 1'b1;
    step(); clr_err = 1'b0; settle();
    chk("ecc_dbe_err_clr", 64'(dbe_err), 64'd0);
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
    chk("ecc_sbe_cnt_clr", 64'(sbe_cnt), 64'd0);
`endif

    // Clear coincident with a new error: set wins
    push_word(48'hC1EA_0000_0001, 1'b1, 1'b1);
    step(); idle();
    step();
    clr_err = 1'b1;
    step(); clr_err = 1'b0; settle();
    chk("clr_vs_set_dbe_err", 64'(dbe_err), 64'd1);
`ifdef MDMA_DESC_FIFO_SBE_CNT_EN
    chk("clr_vs_set_sbe_cnt", 64'(sbe_cnt), 64'd1);
`endif
    wait_empty(10);
    clr_err = 1'b1;
    step(); clr_err = 1'b0; settle();
    chk("final_dbe_err_clr", 64'(dbe_err), 64'd0);

    // Reset mid-stream with a read in flight
    pop_rdy = 1'b0;
    for (int i = 0; i < 37; i++) begin
      push_word({16'h0EE5, 32'(i)}, 1'b0, 1'b0);
      step();
    end
    idle(); step(); step(); settle();
    chk("mr_occ37", 64'(occ), 64'd37);
    pop_rdy = 1'b1;
    push_word({16'h0EE5, 32'd37}, 1'b0, 1'b0);
    chk("mr_ren", 64'(ram_bus.ren), 64'd1);
    step();
    rst = 1'b1; pop_rdy = 1'b0; idle();
    exp_q.delete();
    settle();
    chk("mr_occ_hold", 64'(occ), 64'd37);
    step();
    rst = 1'b0;
    exp_wptr = '0;
    settle();
    chk("mr_occ0", 64'(occ), 64'd0);
    chk("mr_pop_vld", 64'(pop_vld), 64'd0);
    chk("mr_empty", 64'(empty), 64'd1);
    chk("mr_push_rdy", 64'(push_rdy), 64'd1);
    pop_rdy = 1'b1;
    push_word(48'h0AF7_E400_0001, 1'b0, 1'b0);
    step(); idle();
    wait_empty(20);

    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
